// File: rtl/spi_poller_pkg.sv
// Shared types and constants for the SPI encoder poller and its byte shifter.
package spi_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned FRAME_BYTES = 9;
  localparam int unsigned ENC_WIDTH   = 32;
  localparam logic [7:0]  START_ADDR  = 8'h00;

  // Both encoder counts, collected and published together.
  typedef struct packed {
    logic [ENC_WIDTH-1:0] b;
    logic [ENC_WIDTH-1:0] a;
  } enc_pair_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// One full-duplex SPI mode-0 byte exchange: sck divider, MSB-first mosi shift, miso capture on sck rise.
module spi_byte_shifter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       last_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_sh;
  logic             active;
  logic             edge_c;

  assign edge_c = active && run && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Final falling edge of bit 7; a load in this cycle chains the next byte with no gap.
  assign last_c = edge_c && sck && (bit_idx == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bit_idx   <= '0;
      tx_sh     <= '0;
      active    <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= last_c;
      if (load) begin
        tx_sh   <= tx_byte;
        mosi    <= tx_byte[7];
        bit_idx <= '0;
        div_cnt <= '0;
        sck     <= 1'b0;
        active  <= 1'b1;
      end else if (active && run) begin
        if (edge_c) begin
          div_cnt <= '0;
          if (!sck) begin
            sck     <= 1'b1;
            rx_byte <= {rx_byte[6:0], miso};
          end else begin
            sck     <= 1'b0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              active <= 1'b0;
            end else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
              mosi  <= tx_sh[6];
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/spi_encoder_poller.sv
// SPI initiator reading both encoder counts in one 9-byte frame and publishing them atomically.
// Optional periodic polling enabled by defining SPI_AUTO_POLL_EN.
module spi_encoder_poller
  import spi_poller_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned POLL_PERIOD = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 cs,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso,
  output logic [ENC_WIDTH-1:0] encCountA,
  output logic [ENC_WIDTH-1:0] encCountB,
  output logic                 dataValid
);

  localparam int unsigned TMAX      = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_W     = $clog2(TMAX + 2);
  localparam logic [3:0]  LAST_BYTE = 4'(FRAME_BYTES - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("spi_encoder_poller: CLK_DIV must be >= 2");
  end
  if (POLL_PERIOD < 1) begin : g_bad_poll
    $error("spi_encoder_poller: POLL_PERIOD must be >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] tcnt;
  logic [3:0]       byte_idx;
  enc_pair_t        shadow;
  enc_pair_t        shadow_nxt_c;
  logic [1:0]       lane_c;
  logic             tick_c;
  logic             accept_c;
  logic             load_c;
  logic [7:0]       tx_c;
  logic             last_c;
  logic             byte_done;
  logic [7:0]       rx_byte;

`ifdef SPI_AUTO_POLL_EN
  localparam int unsigned POLL_W = $clog2(POLL_PERIOD + 1);
  logic [POLL_W-1:0] poll_cnt;

  assign tick_c = (poll_cnt == POLL_W'(POLL_PERIOD - 1));

  // Free-running poll timer, realigned to every accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (accept_c || tick_c) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end
`else
  assign tick_c = 1'b0;
`endif

  assign accept_c = (state == IDLE) && (start || tick_c);
  assign load_c   = accept_c || ((state == SHIFT) && last_c && (byte_idx != LAST_BYTE));
  assign tx_c     = accept_c ? START_ADDR : 8'h00;
  assign lane_c   = 2'(byte_idx - 4'd1);

  // Place the just-received byte into its lane; byte 0 is the address echo and is dropped.
  always_comb begin
    shadow_nxt_c = shadow;
    if (byte_done) begin
      if ((byte_idx >= 4'd1) && (byte_idx <= 4'd4)) begin
        shadow_nxt_c.a[{lane_c, 3'b000} +: 8] = rx_byte;
      end else if ((byte_idx >= 4'd5) && (byte_idx <= LAST_BYTE)) begin
        shadow_nxt_c.b[{lane_c, 3'b000} +: 8] = rx_byte;
      end
    end
  end

  spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_c),
    .run      (state == SHIFT),
    .tx_byte  (tx_c),
    .miso     (miso),
    .sck      (sck),
    .mosi     (mosi),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .last_c   (last_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      byte_idx  <= '0;
      shadow    <= '0;
      cs        <= 1'b1;
      busy      <= 1'b0;
      dataValid <= 1'b0;
      encCountA <= '0;
      encCountB <= '0;
    end else begin
      dataValid <= 1'b0;
      shadow    <= shadow_nxt_c;
      if (byte_done && (byte_idx != LAST_BYTE)) begin
        byte_idx <= byte_idx + 4'd1;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            state    <= SETUP;
            cs       <= 1'b0;
            busy     <= 1'b1;
            tcnt     <= '0;
            byte_idx <= '0;
          end
        end
        SETUP: begin
          if (tcnt == CNT_W'(CS_SETUP - 1)) begin
            state <= SHIFT;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (last_c && (byte_idx == LAST_BYTE)) begin
            state <= HOLD;
            tcnt  <= '0;
          end
        end
        HOLD: begin
          if (tcnt == CNT_W'(CS_HOLD - 1)) begin
            state     <= DONE;
            cs        <= 1'b1;
            dataValid <= 1'b1;
            encCountA <= shadow_nxt_c.a;
            encCountB <= shadow_nxt_c.b;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_encoder_poller.sv
// Bench for spi_encoder_poller: SPI peripheral model, protocol monitor, directed frame tests.
module tb_spi_encoder_poller;

`ifdef SPI_AUTO_POLL_EN
  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned POLL_PERIOD = 1000;
  localparam int          LAT         = 293;
`else
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned POLL_PERIOD = 100000;
  localparam int          LAT         = 581;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        cs;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic [31:0] encCountA;
  logic [31:0] encCountB;
  logic        dataValid;

  spi_encoder_poller #(
    .CLK_DIV    (CLK_DIV),
    .CS_SETUP   (2),
    .CS_HOLD    (2),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .encCountA(encCountA),
    .encCountB(encCountB),
    .dataValid(dataValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Peripheral model: counts frozen at cs fall, MISO MSB first, changed on sck fall.
  logic [31:0] per_a = '0;
  logic [31:0] per_b = '0;
  logic [71:0] per_sh = '0;
  logic [71:0] mosi_sh = '0;
  int          rise_cnt = 0;

  initial miso = 1'b0;

  always @(negedge cs) begin
    per_sh   = {8'hA5, per_a[7:0], per_a[15:8], per_a[23:16], per_a[31:24],
                per_b[7:0], per_b[15:8], per_b[23:16], per_b[31:24]};
    miso     = per_sh[71];
    rise_cnt = 0;
    mosi_sh  = '0;
  end

  always @(negedge sck) begin
    if (cs === 1'b0) begin
      per_sh = {per_sh[70:0], 1'b0};
      miso   = per_sh[71];
    end
  end

  always @(posedge sck) begin
    if (cs === 1'b0) begin
      mosi_sh = {mosi_sh[70:0], mosi};
      rise_cnt++;
    end
  end

  // Cycle index, dataValid history and protocol rule violations.
  int          cyc = 0;
  int          dv_cnt = 0;
  int          dv_cyc = 0;
  int          dv_prev = 0;
  int          prot_err = 0;
  int          cs_hi_run = 0;
  logic        prev_mosi = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_b = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dataValid === 1'b1) begin
      dv_cnt++;
      dv_prev = dv_cyc;
      dv_cyc  = cyc;
    end
    if (cs === 1'b1 && sck !== 1'b0) prot_err++;
    if (cs === 1'b0 && sck === 1'b1 && mosi !== prev_mosi) prot_err++;
    if (cs === 1'b0 && cs_hi_run == 0 && reset_n === 1'b1 && cyc > 4) prot_err++;
    if (reset_n === 1'b1 && dataValid !== 1'b1 &&
        (encCountA !== prev_a || encCountB !== prev_b)) prot_err++;
    cs_hi_run = (cs === 1'b1) ? cs_hi_run + 1 : ((cs_hi_run > 0 && cs === 1'b0) ? -1 : cs_hi_run);
    prev_mosi = mosi;
    prev_a    = encCountA;
    prev_b    = encCountB;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dv(input int budget, output int n);
    n = 0;
    while (dataValid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("dv_arrived", 64'(dataValid), 64'd1);
  endtask

  // Pulses start for one cycle; lat is the cycle index where dataValid is seen.
  task automatic do_frame(output int lat, output logic busy1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    busy1 = busy;
    lat   = 1;
    while (dataValid !== 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
  endtask

`ifndef SPI_AUTO_POLL_EN
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  task automatic directed();
    vec_t vecs[5];
    int   lat;
    int   n;
    int   c;
    int   d0;
    logic b1;

    vecs[0] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0102_0304, 32'h0506_0708, 32'h0102_0304, 32'h0506_0708};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'h8000_0001, 32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFE};

    for (int i = 0; i < 5; i++) begin
      per_a = vecs[i].a;
      per_b = vecs[i].b;
      do_frame(lat, b1);
      chk("latency", 64'(lat), 64'd581);
      chk("busy_after_start", 64'(b1), 64'd1);
      chk("busy_at_valid", 64'(busy), 64'd1);
      chk("cs_at_valid", 64'(cs), 64'd1);
      chk("enc_a", 64'(encCountA), 64'(vecs[i].exp_a));
      chk("enc_b", 64'(encCountB), 64'(vecs[i].exp_b));
      chk("sck_rises", 64'(rise_cnt), 64'd72);
      chk("mosi_byte0", 64'(mosi_sh[71:64]), 64'h00);
      chk("mosi_rest", mosi_sh[63:0], 64'h0);
      step();
      chk("valid_one_cycle", 64'(dataValid), 64'd0);
      chk("busy_released", 64'(busy), 64'd0);
    end

    // Second start mid-frame must be ignored.
    per_a = 32'h1122_3344;
    per_b = 32'h5566_7788;
    d0    = dv_cnt;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < 100) begin
      step();
      c++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_dv(1000, n);
    chk("ign_enc_a", 64'(encCountA), 64'h1122_3344);
    chk("ign_enc_b", 64'(encCountB), 64'h5566_7788);
    repeat (700) step();
    chk("ign_single_frame", 64'(dv_cnt - d0), 64'd1);
    chk("ign_cs_idle", 64'(cs), 64'd1);

    // Reset in the middle of a frame.
    per_a = 32'hA1B2_C3D4;
    per_b = 32'h0F1E_2D3C;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < 300) begin
      step();
      c++;
    end
    reset_n = 1'b0;
    #1;
    chk("rst_cs", 64'(cs), 64'd1);
    chk("rst_sck", 64'(sck), 64'd0);
    chk("rst_enc_a", 64'(encCountA), 64'd0);
    chk("rst_enc_b", 64'(encCountB), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_frame(lat, b1);
    chk("post_rst_latency", 64'(lat), 64'd581);
    chk("post_rst_enc_a", 64'(encCountA), 64'hA1B2_C3D4);
    chk("post_rst_enc_b", 64'(encCountB), 64'h0F1E_2D3C);
    chk("post_rst_rises", 64'(rise_cnt), 64'd72);

    // Peripheral counts change mid-frame; the frame in flight reports the frozen pair.
    per_a = 32'hCAFE_F00D;
    per_b = 32'h0BAD_C0DE;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < 200) begin
      step();
      c++;
    end
    per_a = 32'h0000_0001;
    per_b = 32'hFFFF_FFFF;
    while (c < 580) begin
      step();
      c++;
    end
    chk("mid_old_a", 64'(encCountA), 64'hA1B2_C3D4);
    chk("mid_old_b", 64'(encCountB), 64'h0F1E_2D3C);
    wait_dv(100, n);
    chk("mid_wait", 64'(n), 64'd1);
    chk("mid_frozen_a", 64'(encCountA), 64'hCAFE_F00D);
    chk("mid_frozen_b", 64'(encCountB), 64'h0BAD_C0DE);
    do_frame(lat, b1);
    chk("mid_new_a", 64'(encCountA), 64'h0000_0001);
    chk("mid_new_b", 64'(encCountB), 64'hFFFF_FFFF);
  endtask
`else
  task automatic auto_poll();
    int n;
    int s;
    int d0;
    n = 0;
    while (dv_cnt < 2 && n < 3000) begin
      step();
      n++;
    end
    chk("auto_two_frames", 64'(dv_cnt >= 2), 64'd1);
    chk("auto_period", 64'(dv_cyc - dv_prev), 64'd1000);
    chk("auto_enc_a", 64'(encCountA), 64'h1234_5678);
    chk("auto_enc_b", 64'(encCountB), 64'hDEAD_BEEF);

    // Start placed exactly on the next timer tick must yield one frame only.
    s = dv_cyc - LAT + 1000;
    while (cyc < s) step();
    start = 1'b1;
    step();
    start = 1'b0;
    d0 = dv_cnt;
    repeat (1500) step();
    chk("auto_coincident_frames", 64'(dv_cnt - d0), 64'd2);
    chk("auto_coincident_first", 64'(dv_prev), 64'(s + LAT));
    chk("auto_period_after", 64'(dv_cyc - dv_prev), 64'd1000);
    chk("auto_rises", 64'(rise_cnt), 64'd72);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
`ifdef SPI_AUTO_POLL_EN
    per_a = 32'h1234_5678;
    per_b = 32'hDEAD_BEEF;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", 64'(cs), 64'd1);
    chk("reset_sck", 64'(sck), 64'd0);
    chk("reset_mosi", 64'(mosi), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_valid", 64'(dataValid), 64'd0);
    chk("reset_enc_a", 64'(encCountA), 64'd0);
    chk("reset_enc_b", 64'(encCountB), 64'd0);
    reset_n = 1'b1;
`ifdef SPI_AUTO_POLL_EN
    auto_poll();
`else
    directed();
`endif
    step();
    chk("protocol_violations", 64'(prot_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
